// File: rtl/mbox_pkg.sv
// Shared constants for the bus mailbox: register offsets, STATUS/CTRL bit
// positions, reset values and the bus handshake state encoding.
package mbox_pkg;

  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_CTRL   = 2'd2;
  localparam logic [1:0] REG_THRESH = 2'd3;

  localparam int ST_EMPTY_BIT = 0;
  localparam int ST_FULL_BIT  = 1;
  localparam int ST_OVF_BIT   = 2;
  localparam int ST_UDF_BIT   = 3;
  localparam int ST_CNT_LSB   = 16;

  localparam int CTRL_IE_BIT    = 0;
  localparam int CTRL_FLUSH_BIT = 1;

  localparam logic [7:0] THRESH_RST = 8'd1;

  typedef enum logic [1:0] {
    MB_IDLE = 2'd0,
    MB_ACK  = 2'd1,
    MB_HOLD = 2'd2
  } mbox_state_e;

  // Fill level has reached the programmed threshold; an empty FIFO never qualifies.
  function automatic logic at_thresh(input logic [8:0] cnt, input logic [7:0] thr);
    return (cnt >= {1'b0, thr}) && (cnt != 9'd0);
  endfunction

endpackage

// File: rtl/mbox_fifo_core.sv
// Mailbox storage: DEPTH-entry FIFO with saturating count, drop-on-full push,
// ignore-on-empty pop and a synchronous flush that wins over push/pop.
module mbox_fifo_core #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 32,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic             flush_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CW-1:0]    count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, wptr_d;
  logic [AW-1:0]    rptr_q, rptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i && !full_o && !flush_i;
  assign do_pop  = pop_i && !empty_o && !flush_i;

  // Pointers are AW bits wide, so they wrap modulo DEPTH on their own.
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (flush_i) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (do_push) wptr_d = wptr_q + 1'b1;
      if (do_pop)  rptr_d = rptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/bus_mailbox.sv
// Bus-slave mailbox: IDLE->ACK->HOLD handshake in front of a FIFO plus
// STATUS/CTRL/THRESH registers. Define MBOX_IRQ_EN to build ie/THRESH/int_o.
module bus_mailbox #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             cs_i,
  input  logic             we_i,
  input  logic [31:0]      adr_i,
  input  logic [WIDTH-1:0] dat_i,
  output logic [WIDTH-1:0] dat_o,
  output logic             ack_o,
  output logic             int_o
);
  import mbox_pkg::*;

  localparam int CW = $clog2(DEPTH) + 1;

  mbox_state_e      state_q, state_d;
  logic [WIDTH-1:0] dat_q, dat_d;
  logic             ovf_q, ovf_d;
  logic             udf_q, udf_d;
  logic             accept;
  logic [1:0]       reg_sel;
  logic             push, pop, flush;
  logic [WIDTH-1:0] head;
  logic             full, empty;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] status_word, ctrl_word, thresh_word;
  logic             unused_adr;

`ifdef MBOX_IRQ_EN
  logic             ie_q, ie_d;
  logic [7:0]       thresh_q, thresh_d;
  logic             int_q, int_d;
`endif

  assign reg_sel    = adr_i[3:2];
  assign unused_adr = ^{adr_i[31:4], adr_i[1:0]};
  assign accept     = (state_q == MB_IDLE) && cs_i;
  assign ack_o      = (state_q == MB_ACK);
  assign dat_o      = dat_q;

  mbox_fifo_core #(
    .DEPTH (DEPTH),
    .WIDTH (WIDTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (flush),
    .wdata_i (dat_i),
    .rdata_o (head),
    .full_o  (full),
    .empty_o (empty),
    .count_o (count)
  );

  // HOLD absorbs the rest of a long cs_i assertion so one select is one access.
  always_comb begin
    state_d = state_q;
    case (state_q)
      MB_IDLE: if (cs_i) state_d = MB_ACK;
      MB_ACK:  state_d = MB_HOLD;
      MB_HOLD: if (!cs_i) state_d = MB_IDLE;
      default: state_d = MB_IDLE;
    endcase
  end

  always_comb begin
    status_word                         = '0;
    status_word[ST_EMPTY_BIT]           = empty;
    status_word[ST_FULL_BIT]            = full;
    status_word[ST_OVF_BIT]             = ovf_q;
    status_word[ST_UDF_BIT]             = udf_q;
    status_word[ST_CNT_LSB +: CW]       = count;
  end

`ifdef MBOX_IRQ_EN
  always_comb begin
    ctrl_word              = '0;
    ctrl_word[CTRL_IE_BIT] = ie_q;
  end
  assign thresh_word = WIDTH'(thresh_q);
`else
  assign ctrl_word   = '0;
  assign thresh_word = '0;
`endif

  // All register side effects happen only on the accepting edge.
  always_comb begin
    dat_d = dat_q;
    ovf_d = ovf_q;
    udf_d = udf_q;
    push  = 1'b0;
    pop   = 1'b0;
    flush = 1'b0;
`ifdef MBOX_IRQ_EN
    ie_d     = ie_q;
    thresh_d = thresh_q;
`endif
    if (accept) begin
      if (we_i) begin
        case (reg_sel)
          REG_DATA: begin
            push = 1'b1;
            if (full) ovf_d = 1'b1;
          end
          REG_STATUS: begin
            if (dat_i[ST_OVF_BIT]) ovf_d = 1'b0;
            if (dat_i[ST_UDF_BIT]) udf_d = 1'b0;
          end
          REG_CTRL: begin
            flush = dat_i[CTRL_FLUSH_BIT];
`ifdef MBOX_IRQ_EN
            ie_d  = dat_i[CTRL_IE_BIT];
`endif
          end
          default: begin
`ifdef MBOX_IRQ_EN
            thresh_d = dat_i[7:0];
`endif
          end
        endcase
      end else begin
        case (reg_sel)
          REG_DATA: begin
            if (empty) begin
              dat_d = '0;
              udf_d = 1'b1;
            end else begin
              dat_d = head;
              pop   = 1'b1;
            end
          end
          REG_STATUS: dat_d = status_word;
          REG_CTRL:   dat_d = ctrl_word;
          default:    dat_d = thresh_word;
        endcase
      end
    end
  end

`ifdef MBOX_IRQ_EN
  always_comb begin
    int_d = ie_q && (at_thresh(9'(count), thresh_q) || ovf_q || udf_q);
  end
  assign int_o = int_q;
`else
  assign int_o = 1'b0;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= MB_IDLE;
      dat_q    <= '0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
`ifdef MBOX_IRQ_EN
      ie_q     <= 1'b0;
      thresh_q <= THRESH_RST;
      int_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      dat_q    <= dat_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
`ifdef MBOX_IRQ_EN
      ie_q     <= ie_d;
      thresh_q <= thresh_d;
      int_q    <= int_d;
`endif
    end
  end

endmodule

// File: tb/tb_bus_mailbox.sv
// Scoreboard bench for bus_mailbox: a queue-based mailbox model predicts each
// access's dat_o and the following int_o; a monitor checks them on every ack.
module tb_bus_mailbox;

  localparam int DEPTH = 16;
  localparam int WIDTH = 32;
`ifdef MBOX_IRQ_EN
  localparam bit IRQ = 1'b1;
`else
  localparam bit IRQ = 1'b0;
`endif

  logic             clk_i = 1'b0;
  logic             rst_i = 1'b1;
  logic             cs_i  = 1'b0;
  logic             we_i  = 1'b0;
  logic [31:0]      adr_i = '0;
  logic [WIDTH-1:0] dat_i = '0;
  logic [WIDTH-1:0] dat_o;
  logic             ack_o;
  logic             int_o;

  bus_mailbox #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .cs_i  (cs_i),
    .we_i  (we_i),
    .adr_i (adr_i),
    .dat_i (dat_i),
    .dat_o (dat_o),
    .ack_o (ack_o),
    .int_o (int_o)
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  logic [31:0] mq[$];
  bit          m_ovf, m_udf, m_ie;
  logic [7:0]  m_thr;
  logic [31:0] m_dat;

  function automatic void model_reset();
    mq.delete();
    m_ovf = 0;
    m_udf = 0;
    m_ie  = 0;
    m_thr = IRQ ? 8'd1 : 8'd0;
    m_dat = 0;
  endfunction

  function automatic logic [31:0] model_status();
    int n;
    n = mq.size();
    return (32'(n) << 16) | (32'(m_udf) << 3) | (32'(m_ovf) << 2)
         | (32'(n == DEPTH) << 1) | 32'(n == 0);
  endfunction

  function automatic void model_access(input bit we, input logic [1:0] sel,
                                       input logic [31:0] d,
                                       output logic [31:0] dat, output bit irq);
    int n;
    if (we) begin
      case (sel)
        2'd0: if (mq.size() == DEPTH) m_ovf = 1; else mq.push_back(d);
        2'd1: begin
          if (d[2]) m_ovf = 0;
          if (d[3]) m_udf = 0;
        end
        2'd2: begin
          if (IRQ) m_ie = d[0];
          if (d[1]) mq.delete();
        end
        default: if (IRQ) m_thr = d[7:0];
      endcase
    end else begin
      case (sel)
        2'd0: if (mq.size() == 0) begin m_dat = 0; m_udf = 1; end
              else m_dat = mq.pop_front();
        2'd1: m_dat = model_status();
        2'd2: m_dat = IRQ ? {31'b0, m_ie} : 32'd0;
        default: m_dat = IRQ ? {24'b0, m_thr} : 32'd0;
      endcase
    end
    dat = m_dat;
    n = mq.size();
    irq = IRQ && m_ie && (((n >= int'(m_thr)) && (n != 0)) || m_ovf || m_udf);
  endfunction

  // ---------------- scoreboard + monitor ----------------
  typedef struct {
    logic [31:0] dat;
    bit          irq;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  bit   int_pend = 0;
  bit   int_exp  = 0;
  bit   prev_ack = 0;

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk_i);
      if (int_pend) begin
        chk("int_o", {31'b0, int_o}, {31'b0, int_exp});
        int_pend = 0;
      end
      if (ack_o === 1'b1) begin
        if (prev_ack) chk("ack_len", 32'd2, 32'd1);
        if (sb.size() == 0) begin
          chk("ack_unexpected", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          chk("dat_o", dat_o, e.dat);
          chk("ack_cycle", cyc, e.cyc);
          int_pend = 1;
          int_exp  = e.irq;
        end
      end
      prev_ack = (ack_o === 1'b1);
    end
  end

  // ---------------- driver ----------------
  task automatic bus_xfer(input bit we, input logic [1:0] sel, input logic [31:0] d,
                          input int hold_extra);
    exp_t        e;
    logic [31:0] a;
    a      = $urandom;
    a[3:2] = sel;
    @(negedge clk_i);
    cs_i  = 1'b1;
    we_i  = we;
    adr_i = a;
    dat_i = d;
    @(posedge clk_i);
    e.cyc = cyc + 1;
    model_access(we, sel, d, e.dat, e.irq);
    sb.push_back(e);
    repeat (hold_extra) @(posedge clk_i);
    @(negedge clk_i);
    cs_i  = 1'b0;
    we_i  = 1'($urandom);
    dat_i = $urandom;
    repeat (2) @(posedge clk_i);
  endtask

  task automatic wr(input logic [1:0] sel, input logic [31:0] d);
    bus_xfer(1'b1, sel, d, 0);
  endtask

  task automatic rd(input logic [1:0] sel);
    bus_xfer(1'b0, sel, 32'h0, 0);
  endtask

  task automatic reset_in_ack();
    @(negedge clk_i);
    cs_i  = 1'b1;
    we_i  = 1'b1;
    adr_i = 32'h0;
    dat_i = $urandom;
    @(posedge clk_i);
    #1;
    chk("ack_before_rst", {31'b0, ack_o}, 32'd1);
    rst_i = 1'b1;
    #1;
    chk("ack_async_drop", {31'b0, ack_o}, 32'd0);
    chk("dat_o_async_rst", dat_o, 32'd0);
    chk("int_o_async_rst", {31'b0, int_o}, 32'd0);
    model_reset();
    @(negedge clk_i);
    cs_i  = 1'b0;
    rst_i = 1'b0;
    repeat (2) @(posedge clk_i);
  endtask

  initial begin : stimulus
    model_reset();
    repeat (3) @(posedge clk_i);
    #2;
    chk("rst_ack_o", {31'b0, ack_o}, 32'd0);
    chk("rst_dat_o", dat_o, 32'd0);
    chk("rst_int_o", {31'b0, int_o}, 32'd0);
    @(negedge clk_i);
    rst_i = 1'b0;

    rd(2'd1);
    rd(2'd3);
    rd(2'd2);

    // Single word round trip.
    wr(2'd0, 32'hA5A5_0001);
    rd(2'd0);
    rd(2'd1);

    // Overflow with one push beyond capacity, then W1C of ovf only.
    for (int i = 0; i < DEPTH + 1; i++) wr(2'd0, 32'h1000_0000 + 32'(i));
    rd(2'd1);
    wr(2'd1, 32'h4);
    rd(2'd1);

    // Underflow with interrupts enabled.
    wr(2'd2, 32'h3);
    wr(2'd2, 32'h1);
    rd(2'd0);
    rd(2'd1);

    // Threshold interrupt and flush.
    wr(2'd1, 32'hC);
    wr(2'd3, 32'hFFFF_FF03);
    rd(2'd3);
    wr(2'd0, 32'h11);
    wr(2'd0, 32'h22);
    wr(2'd0, 32'h33);
    wr(2'd2, 32'h3);
    rd(2'd2);
    rd(2'd1);

    // Long chip select: exactly one access.
    bus_xfer(1'b1, 2'd0, 32'hBEEF_0005, 4);
    rd(2'd1);
    bus_xfer(1'b0, 2'd0, 32'h0, 3);
    rd(2'd1);

    // Reset during the ACK of a fifth push.
    wr(2'd3, 32'h7);
    for (int i = 0; i < 4; i++) wr(2'd0, 32'h2000_0000 + 32'(i));
    reset_in_ack();
    rd(2'd1);
    rd(2'd3);
    rd(2'd2);

    // Randomised traffic.
    for (int i = 0; i < 300; i++) begin
      logic [1:0]  sel;
      logic [31:0] d;
      bit          we;
      sel = 2'($urandom_range(0, 3));
      we  = 1'($urandom_range(0, 1));
      d   = $urandom;
      if (sel == 2'd0 && $urandom_range(0, 2) != 0) we = 1'b1;
      if (sel == 2'd2 && we && $urandom_range(0, 3) != 0) d[1] = 1'b0;
      if (sel == 2'd3 && we && $urandom_range(0, 1) != 0) d[7:0] = 8'($urandom_range(0, 18));
      bus_xfer(we, sel, d, int'($urandom_range(0, 2)));
    end
    rd(2'd1);

    repeat (5) @(posedge clk_i);
    chk("pending_acks", sb.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
